// File: rtl/fm_tx_nco.sv
// FM transmitter core: phase-accumulator NCO with a runtime carrier tuning
// word, frequency-modulated by audio samples taken from a small stream FIFO
// (or an internal square test tone) at a programmable sample rate.
module fm_tx_nco #(
   parameter int P_ACC_W      = 32,
   parameter int P_SMP_W      = 8,
   parameter int P_DEV_SHIFT  = 8,
   parameter int P_FIFO_DEPTH = 4,
   parameter int P_RATE_W     = 16
) (
   input  logic                i_clk,
   input  logic                i_nrst,
   input  logic                i_en,
   input  logic [P_ACC_W-1:0]  i_ftw,
   input  logic [P_RATE_W-1:0] i_rate,
   input  logic [1:0]          i_mode,
   input  logic                i_smp_valid,
   input  logic [P_SMP_W-1:0]  i_smp_data,
   output logic                o_smp_ready,
   input  logic                i_clr_uf,
   output logic                o_underflow,
   output logic                o_fm
);

   localparam int P_PTR_W = $clog2(P_FIFO_DEPTH);

   typedef enum logic [1:0] {
      MODE_CARRIER = 2'b00,
      MODE_STREAM  = 2'b01,
      MODE_TONE    = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_t;

   // Full-scale tone levels: +max and -max of a two's complement sample.
   localparam logic [P_SMP_W-1:0] SMP_POS_MAX = {1'b0, {(P_SMP_W-1){1'b1}}};
   localparam logic [P_SMP_W-1:0] SMP_NEG_MAX = {1'b1, {(P_SMP_W-1){1'b0}}};

   mode_t mode;
   assign mode = mode_t'(i_mode);

   // FIFO storage; pointers carry one extra wrap bit to tell full from empty.
   logic [P_SMP_W-1:0] mem [P_FIFO_DEPTH];
   logic [P_PTR_W:0]   wr_ptr;
   logic [P_PTR_W:0]   rd_ptr;
   logic               fifo_empty;
   logic               fifo_full;
   logic [P_SMP_W-1:0] fifo_head;

   logic [P_RATE_W-1:0] rate_cnt;
   logic                tick;
   logic                push;
   logic                pop;
   logic                uf_set;

   logic [P_SMP_W-1:0]  cur_smp;
   logic                tone_pol;
   logic [P_ACC_W-1:0]  smp_ext;
   logic [P_ACC_W-1:0]  dev;
   logic [P_ACC_W-1:0]  ftw_eff;
   logic [P_ACC_W-1:0]  acc;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[P_PTR_W] != rd_ptr[P_PTR_W]) &&
                        (wr_ptr[P_PTR_W-1:0] == rd_ptr[P_PTR_W-1:0]);
   assign fifo_head   = mem[rd_ptr[P_PTR_W-1:0]];
   assign o_smp_ready = !fifo_full;

   // Decode the per-cycle strobes: sample tick, FIFO push/pop, underflow set.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      tick   = 1'b0;
      push   = 1'b0;
      pop    = 1'b0;
      uf_set = 1'b0;
      if (i_en && (rate_cnt == i_rate)) tick = 1'b1;
      if (i_smp_valid && !fifo_full)    push = 1'b1;
      if (tick && (mode == MODE_STREAM)) begin
         pop    = !fifo_empty;
         uf_set = fifo_empty;
      end
   end

   // Sample storage write; contents are qualified by the pointers only.
   always_ff @(posedge i_clk) begin
      // NOTE: the memory array is deliberately not reset; resetting the pointers already empties the FIFO.
      if (push) mem[wr_ptr[P_PTR_W-1:0]] <= i_smp_data;
   end

   // FIFO pointers: push and pop in the same cycle are both honoured.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!i_nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Sample-rate counter: 0..i_rate while enabled, parked at 0 when disabled.
   // Wrapping on >= keeps the period short if i_rate is lowered mid-count.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         rate_cnt <= '0;
      end else if (!i_en || (rate_cnt >= i_rate)) begin
         rate_cnt <= '0;
      end else begin
         rate_cnt <= rate_cnt + 1'b1;
      end
   end

   // Current modulating sample, selected by mode; carrier mode forces zero.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         cur_smp  <= '0;
         tone_pol <= 1'b0;
      end else begin
         case (mode)
            MODE_STREAM: begin
               if (tick) cur_smp <= fifo_empty ? '0 : fifo_head;
            end
            MODE_TONE: begin
               if (tick) begin
                  tone_pol <= !tone_pol;
                  cur_smp  <= tone_pol ? SMP_NEG_MAX : SMP_POS_MAX;
               end
            end
            default: cur_smp <= '0;
         endcase
      end
   end

   // Sticky underflow flag; a new underflow beats a simultaneous clear.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         o_underflow <= 1'b0;
      end else if (uf_set) begin
         o_underflow <= 1'b1;
      end else if (i_clr_uf) begin
         o_underflow <= 1'b0;
      end
   end

   // Deviation: sign-extend the sample, shift left, drop bits above the MSB.
   assign smp_ext = {{(P_ACC_W-P_SMP_W){cur_smp[P_SMP_W-1]}}, cur_smp};
   assign dev     = smp_ext << P_DEV_SHIFT;

   // Registered effective tuning word (carrier plus deviation).
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         ftw_eff <= '0;
      end else begin
         ftw_eff <= i_ftw + dev;
      end
   end

   // Phase accumulator and registered MSB output; both cleared while disabled.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         acc  <= '0;
         o_fm <= 1'b0;
      end else if (!i_en) begin
         acc  <= '0;
         o_fm <= 1'b0;
      end else begin
         acc  <= acc + ftw_eff;
         o_fm <= acc[P_ACC_W-1];
      end
   end

endmodule

// File: tb/tb_fm_tx_nco.sv
// Directed self-checking bench for fm_tx_nco (16-bit accumulator, 8-bit
// samples, deviation shift 4, 4-entry FIFO).
module tb_fm_tx_nco;

   localparam int ACC_W = 16;
   localparam int SMP_W = 8;
   localparam int RATE_W = 16;

   logic              i_clk;
   logic              i_nrst;
   logic              i_en;
   logic [ACC_W-1:0]  i_ftw;
   logic [RATE_W-1:0] i_rate;
   logic [1:0]        i_mode;
   logic              i_smp_valid;
   logic [SMP_W-1:0]  i_smp_data;
   logic              o_smp_ready;
   logic              i_clr_uf;
   logic              o_underflow;
   logic              o_fm;

   int n_checks = 0;
   int n_errors = 0;

   fm_tx_nco #(
      .P_ACC_W      (ACC_W),
      .P_SMP_W      (SMP_W),
      .P_DEV_SHIFT  (4),
      .P_FIFO_DEPTH (4),
      .P_RATE_W     (RATE_W)
   ) dut (
      .i_clk       (i_clk),
      .i_nrst      (i_nrst),
      .i_en        (i_en),
      .i_ftw       (i_ftw),
      .i_rate      (i_rate),
      .i_mode      (i_mode),
      .i_smp_valid (i_smp_valid),
      .i_smp_data  (i_smp_data),
      .o_smp_ready (o_smp_ready),
      .i_clr_uf    (i_clr_uf),
      .o_underflow (o_underflow),
      .o_fm        (o_fm)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_ftw;
      logic [31:0] exp_smp;

      i_nrst = 1'b0; i_en = 1'b0; i_ftw = '0; i_rate = '0; i_mode = 2'b00;
      i_smp_valid = 1'b0; i_smp_data = '0; i_clr_uf = 1'b0;
      #12;
      check("rst_ready", 32'(o_smp_ready), 32'd1);
      check("rst_uf",    32'(o_underflow), 32'd0);
      check("rst_fm",    32'(o_fm),        32'd0);
      @(negedge i_clk);
      i_nrst = 1'b1;
      step();

      // ---- Stream modulation: push +16 and -16 while disabled ----
      i_smp_valid = 1'b1; i_smp_data = 8'd16;  step();
      i_smp_data = 8'hF0;                       step();
      i_smp_valid = 1'b0;
      i_mode = 2'b01; i_rate = 16'd9; i_ftw = 16'h0100; i_en = 1'b1;
      for (int k = 0; k <= 40; k++) begin
         step();
         // increment: 0x100 until the first tick lands, then 0x200, 0x000, 0x100
         if (k < 10)      exp_ftw = 32'h0100;
         else if (k < 20) exp_ftw = 32'h0200;
         else if (k < 30) exp_ftw = 32'h0000;
         else             exp_ftw = 32'h0100;
         if (k inside {0, 9, 10, 19, 20, 29, 30})
            check($sformatf("stream_ftw_k%0d", k), 32'(dut.ftw_eff), exp_ftw);
         if (k == 8)  check("stream_smp_k8",  32'(dut.cur_smp), 32'h00);
         if (k == 9)  check("stream_smp_k9",  32'(dut.cur_smp), 32'h10);
         if (k == 19) check("stream_smp_k19", 32'(dut.cur_smp), 32'hF0);
         if (k == 29) check("stream_smp_k29", 32'(dut.cur_smp), 32'h00);
         if (k == 28) check("uf_before", 32'(o_underflow), 32'd0);
         if (k == 29) check("uf_set",    32'(o_underflow), 32'd1);
         if (k == 31) check("uf_clr",    32'(o_underflow), 32'd0);
         if (k == 38) check("uf_idle",   32'(o_underflow), 32'd0);
         if (k == 39) check("uf_set_wins", 32'(o_underflow), 32'd1);
         if (k == 1)  check("stream_ready", 32'(o_smp_ready), 32'd1);
         i_clr_uf = (k == 30 || k == 38);
      end
      i_clr_uf = 1'b0;

      // ---- Asynchronous reset mid-stream, checked before any edge ----
      i_nrst = 1'b0;
      #2;
      check("arst_uf",    32'(o_underflow),   32'd0);
      check("arst_ready", 32'(o_smp_ready),   32'd1);
      check("arst_fm",    32'(o_fm),          32'd0);
      check("arst_smp",   32'(dut.cur_smp),   32'd0);
      check("arst_ftw",   32'(dut.ftw_eff),   32'd0);
      check("arst_acc",   32'(dut.acc),       32'd0);
      i_en = 1'b0; i_ftw = '0; i_mode = 2'b00; i_rate = '0;
      @(negedge i_clk);
      i_nrst = 1'b1;
      step();

      // ---- FIFO full / backpressure, then drain at one sample per clock ----
      for (int i = 0; i < 6; i++) begin
         check($sformatf("fill_ready_%0d", i), 32'(o_smp_ready), (i < 4) ? 32'd1 : 32'd0);
         i_smp_valid = 1'b1; i_smp_data = 8'(i + 1);
         step();
      end
      i_smp_valid = 1'b0;
      check("full_ready", 32'(o_smp_ready), 32'd0);
      i_mode = 2'b01; i_rate = 16'd0; i_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         exp_smp = (k < 4) ? 32'(k + 1) : 32'd0;
         check($sformatf("drain_smp_%0d", k), 32'(dut.cur_smp), exp_smp);
         if (k == 0) check("drain_ready", 32'(o_smp_ready), 32'd1);
         if (k == 3) check("drain_uf_clear", 32'(o_underflow), 32'd0);
         if (k == 4) check("drain_uf_set",   32'(o_underflow), 32'd1);
      end

      // ---- Tone mode with two samples parked in the FIFO ----
      i_en = 1'b0;
      step();
      i_smp_valid = 1'b1; i_smp_data = 8'h11; step();
      i_smp_data = 8'h22;                     step();
      i_smp_valid = 1'b0;
      i_mode = 2'b10; i_rate = 16'd4; i_en = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         step();
         if (k < 4)       exp_smp = 32'h00;
         else if (k < 9)  exp_smp = 32'h7F;
         else if (k < 14) exp_smp = 32'h80;
         else             exp_smp = 32'h7F;
         if (k inside {3, 4, 8, 9, 13, 14})
            check($sformatf("tone_smp_k%0d", k), 32'(dut.cur_smp), exp_smp);
         if (k == 1) check("tone_ready_2", 32'(o_smp_ready), 32'd1);
         if (k == 5) check("tone_ready_4", 32'(o_smp_ready), 32'd0);
         i_smp_valid = (k == 1 || k == 2);
         i_smp_data  = 8'h33;
      end
      i_smp_valid = 1'b0;

      // ---- Carrier: ftw 0x1000 gives a period-16 square wave ----
      i_en = 1'b0; i_mode = 2'b00; i_ftw = 16'h1000;
      step();
      check("carr_off_fm",  32'(o_fm),        32'd0);
      check("carr_off_acc", 32'(dut.acc),     32'd0);
      check("carr_smp_zero", 32'(dut.cur_smp), 32'd0);
      step();
      step();
      i_en = 1'b1;
      for (int j = 0; j <= 40; j++) begin
         step();
         check($sformatf("carr_fm_%0d", j), 32'(o_fm), 32'((j >> 3) & 1));
      end
      check("carr_ready", 32'(o_smp_ready), 32'd0);

      // ---- Disable while o_fm is high: output and phase clear, FIFO kept ----
      i_en = 1'b0;
      step();
      check("dis_fm",    32'(o_fm),        32'd0);
      check("dis_acc",   32'(dut.acc),     32'd0);
      check("dis_ready", 32'(o_smp_ready), 32'd0);
      check("dis_uf",    32'(o_underflow), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
